// File: rtl/bin_to_bcd_serial_pkg.sv
// Shared types and constants for the serial shift-and-add-3 binary-to-BCD converter.
package bin_to_bcd_serial_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CONV   = 2'd1,
    ST_FINISH = 2'd2
  } state_e;

  localparam logic [3:0] ADD3_THRESH = 4'd5;
  localparam logic [3:0] ADD3_CORR   = 4'd3;

  // Largest value representable in the given number of decimal digits.
  function automatic int max_val(input int digits);
    int r;
    r = 1;
    for (int i = 0; i < digits; i++) begin
      r = r * 10;
    end
    return r - 1;
  endfunction

endpackage

// File: rtl/bin_to_bcd_serial_add3_digit.sv
// One BCD nibble correction step: values of five or more get three added, with no
// carry out, so that the following left shift produces a valid decimal digit.
module bcd_add3_digit
  import bin_to_bcd_serial_pkg::*;
(
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= ADD3_THRESH) ? (din + ADD3_CORR) : din;

endmodule

// File: rtl/bin_to_bcd_serial.sv
// Sequential binary-to-BCD converter, one input bit per clock. Results above the
// displayable range saturate to all nines and raise OVF.
module bin_to_bcd_serial
  import bin_to_bcd_serial_pkg::*;
#(
  parameter int BIN_WIDTH = 14,
  parameter int DIGITS    = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic [BIN_WIDTH-1:0]  BIN,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [4*DIGITS-1:0]   BCD,
  output logic                  OVF
);

  localparam int MAX_VAL = max_val(DIGITS);
  localparam int BW      = 4 * DIGITS;
  localparam int SW      = BW + BIN_WIDTH;
  localparam int CW      = (BIN_WIDTH > 1) ? $clog2(BIN_WIDTH) : 1;
  localparam logic [CW-1:0]        CNT_INIT = CW'(BIN_WIDTH - 1);
  localparam logic [BIN_WIDTH-1:0] SAT_VAL  = BIN_WIDTH'(MAX_VAL);

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [SW-1:0]        scr_q, scr_d;
  logic                 ovf_flag_q, ovf_flag_d;
  logic [BW-1:0]        bcd_q, bcd_d;
  logic                 ovf_q, ovf_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                 bin_big_s;
  logic [BIN_WIDTH-1:0] src_s;
  logic [SW-1:0]        scr_fix_s;

  assign bin_big_s = (32'(BIN) > MAX_VAL);
  assign src_s     = bin_big_s ? SAT_VAL : BIN;

  // Binary part passes through; each BCD nibble gets its own add-3 correction.
  assign scr_fix_s[BIN_WIDTH-1:0] = scr_q[BIN_WIDTH-1:0];
  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_add3_digit u_add3 (
      .din  (scr_q[BIN_WIDTH+4*i +: 4]),
      .dout (scr_fix_s[BIN_WIDTH+4*i +: 4])
    );
  end

  // Next-state, datapath and output-register inputs.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    scr_d      = scr_q;
    ovf_flag_d = ovf_flag_q;
    bcd_d      = bcd_q;
    ovf_d      = ovf_q;
    busy_d     = (state_q == ST_CONV);
    done_d     = (state_q == ST_FINISH);
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          state_d    = ST_CONV;
          cnt_d      = CNT_INIT;
          scr_d      = {{BW{1'b0}}, src_s};
          ovf_flag_d = bin_big_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CONV: begin
        scr_d = scr_fix_s << 1;
        if (cnt_q == {CW{1'b0}}) begin
          state_d = ST_FINISH;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_FINISH: begin
        bcd_d = scr_q[SW-1 -: BW];
        ovf_d = ovf_flag_q;
        // Back-to-back accept keeps throughput at one result per BIN_WIDTH+1 cycles.
        if (START) begin
          state_d    = ST_CONV;
          cnt_d      = CNT_INIT;
          scr_d      = {{BW{1'b0}}, src_s};
          ovf_flag_d = bin_big_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      cnt_q      <= {CW{1'b0}};
      scr_q      <= {SW{1'b0}};
      ovf_flag_q <= 1'b0;
      bcd_q      <= {BW{1'b0}};
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      scr_q      <= scr_d;
      ovf_flag_q <= ovf_flag_d;
      bcd_q      <= bcd_d;
      ovf_q      <= ovf_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign BUSY = busy_q;
  assign DONE = done_q;
  assign BCD  = bcd_q;
  assign OVF  = ovf_q;

endmodule
